// File: rtl/mem_arbiter.sv
// Main-memory front end: arbitrates I-cache and D-cache line requests onto one
// memory port with a fixed, deterministic access latency.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_line,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wline,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_line,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wline,
    input  logic [LINE_W-1:0] mem_rline
);

    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              last_d_r, last_d_s;   // 1: D-cache won the last grant
    logic              src_d_r, src_d_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [LINE_W-1:0] wline_r, wline_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_we_r, mem_we_s;
    logic              i_ack_r, i_ack_s;
    logic              d_ack_r, d_ack_s;
    logic [LINE_W-1:0] i_line_r, i_line_s;
    logic [LINE_W-1:0] d_line_r, d_line_s;
    logic              d_req_s;
    logic              grant_d_s;

    // Next-state, arbitration and registered-output decode
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        last_d_s  = last_d_r;
        src_d_s   = src_d_r;
        we_s      = we_r;
        addr_s    = addr_r;
        wline_s   = wline_r;
        i_line_s  = i_line_r;
        d_line_s  = d_line_r;
        d_req_s   = d_rd | d_wr;
        grant_d_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_req || d_req_s) begin
                    // On a tie the side not served last wins
                    grant_d_s = d_req_s && (!i_req || !last_d_r);
                    src_d_s   = grant_d_s;
                    last_d_s  = grant_d_s;
                    we_s      = grant_d_s && d_wr;
                    addr_s    = (grant_d_s ? d_addr : i_addr) & ALIGN_MASK;
                    wline_s   = grant_d_s ? d_wline : {LINE_W{1'b0}};
                    cnt_s     = CNT_LOAD;
                    state_s   = ST_BUSY;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_RESP;
                    if (!we_r) begin
                        if (src_d_r) begin
                            d_line_s = mem_rline;
                        end else begin
                            i_line_s = mem_rline;
                        end
                    end else begin
                        d_line_s = d_line_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        mem_en_s = (state_s == ST_BUSY) && (cnt_s == CNT_ZERO);
        mem_we_s = mem_en_s && we_s;
        i_ack_s  = (state_s == ST_RESP) && !src_d_s;
        d_ack_s  = (state_s == ST_RESP) && src_d_s;
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            last_d_r <= 1'b0;
            src_d_r  <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wline_r  <= {LINE_W{1'b0}};
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            i_ack_r  <= 1'b0;
            d_ack_r  <= 1'b0;
            i_line_r <= {LINE_W{1'b0}};
            d_line_r <= {LINE_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            last_d_r <= last_d_s;
            src_d_r  <= src_d_s;
            we_r     <= we_s;
            addr_r   <= addr_s;
            wline_r  <= wline_s;
            mem_en_r <= mem_en_s;
            mem_we_r <= mem_we_s;
            i_ack_r  <= i_ack_s;
            d_ack_r  <= d_ack_s;
            i_line_r <= i_line_s;
            d_line_r <= d_line_s;
        end
    end

    assign i_ack     = i_ack_r;
    assign d_ack     = d_ack_r;
    assign i_line    = i_line_r;
    assign d_line    = d_line_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wline = wline_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: bench-side memory model plus queue scoreboard of
// expected memory strobes and acks, with cycle-exact timing.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int LATENCY = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [LINE_W-1:0] i_line;
    logic              d_rd, d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wline;
    logic              d_ack;
    logic [LINE_W-1:0] d_line;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wline;
    logic [LINE_W-1:0] mem_rline;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [LINE_W-1:0] exp_dline;

    typedef struct { int cyc; logic src_d; logic [LINE_W-1:0] line; } ack_t;
    typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic we; logic [LINE_W-1:0] wline; } mev_t;
    ack_t obs_ack[$], exp_ack[$];
    mev_t obs_mem[$], exp_mem[$];

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_line(i_line),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wline(d_wline),
        .d_ack(d_ack), .d_line(d_line),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wline(mem_wline), .mem_rline(mem_rline)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten lines return an address-derived pattern
    function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'h11111111};
    endfunction

    bit [LINE_W-1:0] mem [256];
    bit              vld [256];
    assign mem_rline = vld[mem_addr[11:4]] ? mem[mem_addr[11:4]] : pat(mem_addr);
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr[11:4]] <= mem_wline;
            vld[mem_addr[11:4]] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mem_en) obs_mem.push_back('{cyc, mem_addr, mem_we, mem_wline});
        if (i_ack)  obs_ack.push_back('{cyc, 1'b0, i_line});
        if (d_ack)  obs_ack.push_back('{cyc, 1'b1, d_line});
    end

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (i_ack) i_req = 1'b0;
            if (d_ack) begin d_rd = 1'b0; d_wr = 1'b0; end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        obs_ack.delete(); obs_mem.delete(); exp_ack.delete(); exp_mem.delete();
        exp_dline = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wline = '0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({i_ack, d_ack, mem_en, mem_we} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_strobes: got %b, expected 0000", {i_ack, d_ack, mem_en, mem_we}); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
        n_checks++; if (mem_wline !== '0) begin n_fail++; $display("FAIL reset_mem_wline: got %h, expected 0", mem_wline); end
        n_checks++; if (i_line !== '0) begin n_fail++; $display("FAIL reset_i_line: got %h, expected 0", i_line); end
        n_checks++; if (d_line !== '0) begin n_fail++; $display("FAIL reset_d_line: got %h, expected 0", d_line); end
        i_req = 1'b1; d_wr = 1'b1; d_addr = 32'h40;
        repeat (3) @(negedge clk);
        i_req = 1'b0; d_wr = 1'b0; rst = 1'b1;
        run_cycles(8);
        n_checks++; if (obs_mem.size() != 0) begin n_fail++; $display("FAIL reset_no_mem_en: got %0d strobes, expected 0", obs_mem.size()); end
        n_checks++; if (obs_ack.size() != 0) begin n_fail++; $display("FAIL reset_no_ack: got %0d acks, expected 0", obs_ack.size()); end
        obs_ack.delete(); obs_mem.delete();
        exp_dline = '0;
    endtask

    task automatic test_i_read();
        int r;
        ack_t ea, oa;
        mev_t em, om;
        @(negedge clk); r = cyc;
        i_addr = 32'h104; i_req = 1'b1;
        exp_mem.push_back('{r + LATENCY, 32'h100, 1'b0, '0});
        exp_ack.push_back('{r + LATENCY + 1, 1'b0, pat(32'h100)});
        run_cycles(2);
        i_addr = 32'h208;
        run_cycles(LATENCY + 4);
        n_checks++; if (obs_mem.size() != exp_mem.size() || obs_ack.size() != exp_ack.size()) begin n_fail++;
            $display("FAIL i_read_counts: got mem=%0d ack=%0d, expected mem=%0d ack=%0d",
                     obs_mem.size(), obs_ack.size(), exp_mem.size(), exp_ack.size()); end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            em = exp_mem.pop_front(); om = obs_mem.pop_front(); n_checks++;
            if (om.cyc !== em.cyc || om.addr !== em.addr || om.we !== em.we) begin n_fail++;
                $display("FAIL i_read_mem: got cyc=%0d addr=%h we=%b, expected cyc=%0d addr=%h we=%b",
                         om.cyc, om.addr, om.we, em.cyc, em.addr, em.we); end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front(); n_checks++;
            if (oa.cyc !== ea.cyc || oa.src_d !== ea.src_d || oa.line !== ea.line) begin n_fail++;
                $display("FAIL i_read_ack: got cyc=%0d d=%b line=%h, expected cyc=%0d d=%b line=%h",
                         oa.cyc, oa.src_d, oa.line, ea.cyc, ea.src_d, ea.line); end
        end
        n_checks++; if (i_line !== pat(32'h100)) begin n_fail++; $display("FAIL i_line_hold: got %h, expected %h", i_line, pat(32'h100)); end
        exp_mem.delete(); obs_mem.delete(); exp_ack.delete(); obs_ack.delete();
    endtask

    task automatic test_writeback();
        int r;
        ack_t ea, oa;
        mev_t em, om;
        logic [LINE_W-1:0] a5;
        a5 = {16{8'hA5}};
        @(negedge clk); r = cyc;
        d_addr = 32'h40; d_wline = a5; d_wr = 1'b1;
        exp_mem.push_back('{r + LATENCY, 32'h40, 1'b1, a5});
        exp_ack.push_back('{r + LATENCY + 1, 1'b1, exp_dline});
        run_cycles(LATENCY + 4);
        @(negedge clk); r = cyc;
        d_addr = 32'h4C; d_wline = '0; d_rd = 1'b1;
        exp_mem.push_back('{r + LATENCY, 32'h40, 1'b0, '0});
        exp_ack.push_back('{r + LATENCY + 1, 1'b1, a5});
        exp_dline = a5;
        run_cycles(LATENCY + 4);
        n_checks++; if (obs_mem.size() != exp_mem.size() || obs_ack.size() != exp_ack.size()) begin n_fail++;
            $display("FAIL wb_counts: got mem=%0d ack=%0d, expected mem=%0d ack=%0d",
                     obs_mem.size(), obs_ack.size(), exp_mem.size(), exp_ack.size()); end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            em = exp_mem.pop_front(); om = obs_mem.pop_front(); n_checks++;
            if (om.cyc !== em.cyc || om.addr !== em.addr || om.we !== em.we || (em.we && om.wline !== em.wline)) begin n_fail++;
                $display("FAIL wb_mem: got cyc=%0d addr=%h we=%b wl=%h, expected cyc=%0d addr=%h we=%b wl=%h",
                         om.cyc, om.addr, om.we, om.wline, em.cyc, em.addr, em.we, em.wline); end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front(); n_checks++;
            if (oa.cyc !== ea.cyc || oa.src_d !== ea.src_d || oa.line !== ea.line) begin n_fail++;
                $display("FAIL wb_ack: got cyc=%0d d=%b line=%h, expected cyc=%0d d=%b line=%h",
                         oa.cyc, oa.src_d, oa.line, ea.cyc, ea.src_d, ea.line); end
        end
        exp_mem.delete(); obs_mem.delete(); exp_ack.delete(); obs_ack.delete();
    endtask

    task automatic test_tie();
        int r;
        bit first_done, pend;
        ack_t ea, oa;
        mev_t em, om;
        apply_reset();
        @(negedge clk); r = cyc;
        i_addr = 32'h500; i_req = 1'b1; d_addr = 32'h300; d_rd = 1'b1;
        exp_mem.push_back('{r + LATENCY, 32'h300, 1'b0, '0});
        exp_ack.push_back('{r + LATENCY + 1, 1'b1, pat(32'h300)});
        exp_mem.push_back('{r + 2 * LATENCY + 2, 32'h500, 1'b0, '0});
        exp_ack.push_back('{r + 2 * LATENCY + 3, 1'b0, pat(32'h500)});
        exp_mem.push_back('{r + 3 * LATENCY + 4, 32'h340, 1'b0, '0});
        exp_ack.push_back('{r + 3 * LATENCY + 5, 1'b1, pat(32'h340)});
        exp_dline = pat(32'h340);
        first_done = 1'b0; pend = 1'b0;
        for (int c = 0; c < 3 * LATENCY + 10; c++) begin
            @(negedge clk);
            if (i_ack) i_req = 1'b0;
            if (d_ack) begin
                d_rd = 1'b0;
                if (!first_done) begin first_done = 1'b1; pend = 1'b1; end
            end else if (pend) begin
                d_addr = 32'h340; d_rd = 1'b1; pend = 1'b0;
            end
        end
        #1;
        n_checks++; if (obs_mem.size() != exp_mem.size() || obs_ack.size() != exp_ack.size()) begin n_fail++;
            $display("FAIL tie_counts: got mem=%0d ack=%0d, expected mem=%0d ack=%0d",
                     obs_mem.size(), obs_ack.size(), exp_mem.size(), exp_ack.size()); end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            em = exp_mem.pop_front(); om = obs_mem.pop_front(); n_checks++;
            if (om.cyc !== em.cyc || om.addr !== em.addr || om.we !== em.we) begin n_fail++;
                $display("FAIL tie_mem: got cyc=%0d addr=%h we=%b, expected cyc=%0d addr=%h we=%b",
                         om.cyc, om.addr, om.we, em.cyc, em.addr, em.we); end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front(); n_checks++;
            if (oa.cyc !== ea.cyc || oa.src_d !== ea.src_d || oa.line !== ea.line) begin n_fail++;
                $display("FAIL tie_ack: got cyc=%0d d=%b line=%h, expected cyc=%0d d=%b line=%h",
                         oa.cyc, oa.src_d, oa.line, ea.cyc, ea.src_d, ea.line); end
        end
        exp_mem.delete(); obs_mem.delete(); exp_ack.delete(); obs_ack.delete();
    endtask

    task automatic test_rdwr_both();
        int r;
        ack_t ea, oa;
        mev_t em, om;
        logic [LINE_W-1:0] l5a;
        l5a = {16{8'h5A}};
        @(negedge clk); r = cyc;
        d_addr = 32'h80; d_wline = l5a; d_rd = 1'b1; d_wr = 1'b1;
        exp_mem.push_back('{r + LATENCY, 32'h80, 1'b1, l5a});
        exp_ack.push_back('{r + LATENCY + 1, 1'b1, exp_dline});
        run_cycles(LATENCY + 8);
        n_checks++; if (obs_mem.size() != exp_mem.size() || obs_ack.size() != exp_ack.size()) begin n_fail++;
            $display("FAIL rdwr_counts: got mem=%0d ack=%0d, expected mem=%0d ack=%0d",
                     obs_mem.size(), obs_ack.size(), exp_mem.size(), exp_ack.size()); end
        while (exp_mem.size() > 0 && obs_mem.size() > 0) begin
            em = exp_mem.pop_front(); om = obs_mem.pop_front(); n_checks++;
            if (om.cyc !== em.cyc || om.addr !== em.addr || om.we !== em.we || om.wline !== em.wline) begin n_fail++;
                $display("FAIL rdwr_mem: got cyc=%0d addr=%h we=%b wl=%h, expected cyc=%0d addr=%h we=%b wl=%h",
                         om.cyc, om.addr, om.we, om.wline, em.cyc, em.addr, em.we, em.wline); end
        end
        while (exp_ack.size() > 0 && obs_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = obs_ack.pop_front(); n_checks++;
            if (oa.cyc !== ea.cyc || oa.src_d !== ea.src_d || oa.line !== ea.line) begin n_fail++;
                $display("FAIL rdwr_ack: got cyc=%0d d=%b line=%h, expected cyc=%0d d=%b line=%h",
                         oa.cyc, oa.src_d, oa.line, ea.cyc, ea.src_d, ea.line); end
        end
        n_checks++; if (d_line !== exp_dline) begin n_fail++; $display("FAIL rdwr_d_line: got %h, expected %h", d_line, exp_dline); end
        exp_mem.delete(); obs_mem.delete(); exp_ack.delete(); obs_ack.delete();
    endtask

    task automatic test_reset_mid();
        int r;
        ack_t oa;
        mev_t om;
        @(negedge clk);
        d_addr = 32'hC0; d_rd = 1'b1;
        run_cycles(3);
        rst = 1'b0; d_rd = 1'b0;
        #1;
        n_checks++; if ({i_ack, d_ack, mem_en, mem_we} !== 4'b0000) begin n_fail++;
            $display("FAIL mid_reset_strobes: got %b, expected 0000", {i_ack, d_ack, mem_en, mem_we}); end
        n_checks++; if (mem_addr !== '0 || mem_wline !== '0) begin n_fail++;
            $display("FAIL mid_reset_mem_bus: got addr=%h wl=%h, expected 0", mem_addr, mem_wline); end
        n_checks++; if (i_line !== '0 || d_line !== '0) begin n_fail++;
            $display("FAIL mid_reset_lines: got i=%h d=%h, expected 0", i_line, d_line); end
        run_cycles(2);
        rst = 1'b1;
        exp_dline = '0;
        run_cycles(10);
        n_checks++; if (obs_mem.size() != 0) begin n_fail++; $display("FAIL mid_reset_no_mem_en: got %0d strobes, expected 0", obs_mem.size()); end
        n_checks++; if (obs_ack.size() != 0) begin n_fail++; $display("FAIL mid_reset_no_ack: got %0d acks, expected 0", obs_ack.size()); end
        obs_mem.delete(); obs_ack.delete();
        @(negedge clk); r = cyc;
        d_addr = 32'hC0; d_rd = 1'b1;
        run_cycles(LATENCY + 4);
        n_checks++; if (obs_mem.size() != 1 || obs_ack.size() != 1) begin n_fail++;
            $display("FAIL reissue_counts: got mem=%0d ack=%0d, expected mem=1 ack=1", obs_mem.size(), obs_ack.size()); end
        if (obs_mem.size() > 0) begin
            om = obs_mem.pop_front(); n_checks++;
            if (om.cyc !== r + LATENCY || om.addr !== 32'hC0 || om.we !== 1'b0) begin n_fail++;
                $display("FAIL reissue_mem: got cyc=%0d addr=%h we=%b, expected cyc=%0d addr=000000c0 we=0",
                         om.cyc, om.addr, om.we, r + LATENCY); end
        end
        if (obs_ack.size() > 0) begin
            oa = obs_ack.pop_front(); n_checks++;
            if (oa.cyc !== r + LATENCY + 1 || oa.src_d !== 1'b1 || oa.line !== pat(32'hC0)) begin n_fail++;
                $display("FAIL reissue_ack: got cyc=%0d d=%b line=%h, expected cyc=%0d d=1 line=%h",
                         oa.cyc, oa.src_d, oa.line, r + LATENCY + 1, pat(32'hC0)); end
        end
        obs_mem.delete(); obs_ack.delete();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_writeback();
        test_tie();
        test_rdwr_both();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
